// File: rtl/elevator_pkg.sv
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared types and default timing constants for the elevator
//                car door sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

    // Door sequencer states
    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } door_state_t;

    // Default timing: one door travel, dwell time, reopens before nudge
    localparam int c_default_move_cyc    = 100;
    localparam int c_default_dwell_cyc   = 300;
    localparam int c_default_reopen_lim  = 3;
    // Timer width; must hold max(2*move, dwell)
    localparam int c_default_cnt_w       = 20;

endpackage : elevator_pkg

`default_nettype wire

// File: rtl/door_timer.sv
// ============================================================================
//  Module      : door_timer
//  Description : Loadable down-counter for door travel and dwell timing.
//                Load has priority over hold; the count saturates at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module door_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    // Load a new interval, or count down one step per clock until zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (!hold && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule : door_timer

`default_nettype wire

// File: rtl/door_controller.sv
// ============================================================================
//  Module      : door_controller
//  Description : Elevator car-door sequencer. Runs the open / dwell / close
//                cycle, reopens on obstruction or open request, and holds the
//                door open while the car is overweight.
//                Optional feature macro: DOOR_NUDGE_EN (forced slow close
//                with buzzer after REOPEN_LIMIT consecutive reopens).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module door_controller
    import elevator_pkg::*;
#(
    parameter int MOVE_TIME_CYC = c_default_move_cyc,
    parameter int DWELL_CYC     = c_default_dwell_cyc,
    parameter int REOPEN_LIMIT  = c_default_reopen_lim,
    parameter int CNT_W         = c_default_cnt_w
) (
    input  logic clk,
    input  logic rst,
    input  logic open_req,
    input  logic close_req,
    input  logic car_stopped,
    input  logic obstruction,
    input  logic weight_over,
    output logic motor_open,
    output logic motor_close,
    output logic door_status,
    output logic door_locked,
    output logic nudge
);

    localparam int RC_W = (REOPEN_LIMIT > 0) ? $clog2(REOPEN_LIMIT + 1) : 1;

    localparam logic [CNT_W-1:0] c_move_load  = CNT_W'(MOVE_TIME_CYC - 1);
    localparam logic [CNT_W-1:0] c_nudge_load = CNT_W'(2 * MOVE_TIME_CYC - 1);
    localparam logic [CNT_W-1:0] c_dwell_load = CNT_W'(DWELL_CYC - 1);
    localparam logic [RC_W-1:0]  c_reopen_max = RC_W'(REOPEN_LIMIT);

`ifdef DOOR_NUDGE_EN
    localparam logic c_nudge_en = 1'b1;
`else
    localparam logic c_nudge_en = 1'b0;
`endif

    door_state_t      r_state;
    door_state_t      w_next_state;
    logic [RC_W-1:0]  r_reopen_cnt;
    logic             r_nudge;

    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_hold;
    logic             w_zero;
    logic             w_reopen;
    logic             w_close_done;
    logic             w_start_close;
    logic             w_nudge_start;

    // A close that starts with the reopen count at its limit is a nudge close
    assign w_nudge_start = c_nudge_en && (r_reopen_cnt == c_reopen_max);

    door_timer #(
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .hold     (w_hold),
        .zero     (w_zero)
    );

    // Next-state decision and timer control for the current state and inputs
    always_comb begin
        w_next_state  = r_state;
        w_load        = 1'b0;
        w_load_val    = '0;
        w_hold        = 1'b0;
        w_reopen      = 1'b0;
        w_close_done  = 1'b0;
        w_start_close = 1'b0;
        case (r_state)
            CLOSED: begin
                w_hold = 1'b1;
                if (open_req && car_stopped) begin
                    w_next_state = OPENING;
                    w_load       = 1'b1;
                    w_load_val   = c_move_load;
                end
            end
            OPENING: begin
                if (w_zero) begin
                    w_next_state = OPEN;
                    w_load       = 1'b1;
                    w_load_val   = c_dwell_load;
                end
            end
            OPEN: begin
                // Open request restarts dwell even if close is pressed too
                if (open_req) begin
                    w_load     = 1'b1;
                    w_load_val = c_dwell_load;
                end else if (w_zero && !weight_over && !obstruction) begin
                    w_next_state  = CLOSING;
                    w_start_close = 1'b1;
                    w_load        = 1'b1;
                    w_load_val    = w_nudge_start ? c_nudge_load : c_move_load;
                end else if (close_req) begin
                    w_load     = 1'b1;
                    w_load_val = '0;
                end
            end
            CLOSING: begin
                // Reopen is checked before travel end so safety always wins
                if (open_req || (obstruction && !r_nudge)) begin
                    w_next_state = OPENING;
                    w_reopen     = 1'b1;
                    w_load       = 1'b1;
                    w_load_val   = c_move_load;
                end else if (w_zero) begin
                    w_next_state = CLOSED;
                    w_close_done = 1'b1;
                end
            end
            default: begin
                w_next_state = CLOSED;
            end
        endcase
    end

    // State, reopen counter, nudge flag and registered output decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= CLOSED;
            r_reopen_cnt <= '0;
            r_nudge      <= 1'b0;
            motor_open   <= 1'b0;
            motor_close  <= 1'b0;
            door_status  <= 1'b0;
            door_locked  <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_reopen) begin
                if (r_reopen_cnt != c_reopen_max) begin
                    r_reopen_cnt <= r_reopen_cnt + RC_W'(1);
                end
            end else if (w_close_done) begin
                r_reopen_cnt <= '0;
            end
            r_nudge     <= (w_start_close && w_nudge_start) ||
                           (r_nudge && (w_next_state == CLOSING));
            motor_open  <= (w_next_state == OPENING);
            motor_close <= (w_next_state == CLOSING);
            door_status <= (w_next_state != CLOSED);
            door_locked <= (w_next_state == CLOSED);
        end
    end

    assign nudge = r_nudge;

endmodule : door_controller

`default_nettype wire

// File: tb/tb_door_controller.sv
// ============================================================================
//  Module      : tb_door_controller
//  Description : Randomized scoreboard bench for door_controller with a
//                behavioural door model (phase + elapsed clocks).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_door_controller;

    localparam int MOVE   = 4;
    localparam int DWELL  = 6;
    localparam int LIMIT  = 2;
    localparam int CYCLES = 4000;

`ifdef DOOR_NUDGE_EN
    localparam bit NUDGE_ON = 1'b1;
`else
    localparam bit NUDGE_ON = 1'b0;
`endif

    // Model phases
    localparam int P_SHUT    = 0;
    localparam int P_RISING  = 1;
    localparam int P_HELD    = 2;
    localparam int P_LOWER   = 3;

    // {motor_open, motor_close, door_status, door_locked, nudge}
    localparam logic [4:0] RESET_EXP = 5'b00010;

    logic clk = 1'b0;
    logic rst;
    logic open_req, close_req, car_stopped, obstruction, weight_over;
    logic motor_open, motor_close, door_status, door_locked, nudge;

    always #5 clk = ~clk;

    door_controller #(
        .MOVE_TIME_CYC (MOVE),
        .DWELL_CYC     (DWELL),
        .REOPEN_LIMIT  (LIMIT),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .open_req    (open_req),
        .close_req   (close_req),
        .car_stopped (car_stopped),
        .obstruction (obstruction),
        .weight_over (weight_over),
        .motor_open  (motor_open),
        .motor_close (motor_close),
        .door_status (door_status),
        .door_locked (door_locked),
        .nudge       (nudge)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [4:0] exp_q[$];

    // Behavioural model state
    int m_phase;
    int m_elapsed;
    int m_reopens;
    bit m_nudge;

    function automatic logic [4:0] dut_outs();
        return {motor_open, motor_close, door_status, door_locked, nudge};
    endfunction

    function automatic logic [4:0] model_outs();
        logic [4:0] v;
        v[4] = (m_phase == P_RISING);
        v[3] = (m_phase == P_LOWER);
        v[2] = (m_phase != P_SHUT);
        v[1] = (m_phase == P_SHUT);
        v[0] = (m_phase == P_LOWER) && m_nudge;
        return v;
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got mo/mc/ds/dl/nu=%b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_SHUT;
        m_elapsed = 0;
        m_reopens = 0;
        m_nudge   = 1'b0;
    endtask

    // Advance the door model by one clock using the currently driven inputs
    task automatic model_step();
        int travel;
        case (m_phase)
            P_SHUT: begin
                if (open_req && car_stopped) begin
                    m_phase   = P_RISING;
                    m_elapsed = 0;
                end
            end
            P_RISING: begin
                if (m_elapsed == MOVE - 1) begin
                    m_phase   = P_HELD;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end
            P_HELD: begin
                if (open_req) begin
                    m_elapsed = 0;
                end else if (m_elapsed >= DWELL - 1 && !weight_over && !obstruction) begin
                    m_phase   = P_LOWER;
                    m_elapsed = 0;
                    m_nudge   = NUDGE_ON && (m_reopens == LIMIT);
                end else if (close_req) begin
                    m_elapsed = DWELL - 1;
                end else if (m_elapsed < DWELL - 1) begin
                    m_elapsed++;
                end
            end
            default: begin
                travel = m_nudge ? 2 * MOVE : MOVE;
                if (open_req || (obstruction && !m_nudge)) begin
                    m_phase   = P_RISING;
                    m_elapsed = 0;
                    m_nudge   = 1'b0;
                    if (m_reopens < LIMIT) m_reopens++;
                end else if (m_elapsed == travel - 1) begin
                    m_phase   = P_SHUT;
                    m_reopens = 0;
                    m_nudge   = 1'b0;
                end else begin
                    m_elapsed++;
                end
            end
        endcase
    endtask

    // Monitor: compare DUT outputs against queued expectations each cycle
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", dut_outs(), e);
            end
        end
    end

    // Stimulus: randomized inputs, model update, expectation push
    initial begin
        rst         = 1'b0;
        open_req    = 1'b0;
        close_req   = 1'b0;
        car_stopped = 1'b0;
        obstruction = 1'b0;
        weight_over = 1'b0;
        model_reset();
        exp_q.push_back(RESET_EXP);

        for (int i = 0; i < CYCLES; i++) begin
            @(negedge clk);
            #2;
            cyc = i;
            if ((i > 10) && (((m_phase == P_RISING) && ($urandom_range(0, 9) == 0)) ||
                             ($urandom_range(0, 499) == 0))) begin
                rst = 1'b0;
                #1;
                check("async_reset", dut_outs(), RESET_EXP);
                model_reset();
                exp_q.push_back(RESET_EXP);
            end else begin
                rst         = 1'b1;
                open_req    = ($urandom_range(0, 99) < 6);
                close_req   = ($urandom_range(0, 99) < 10);
                car_stopped = ($urandom_range(0, 99) < 85);
                obstruction = ($urandom_range(0, 99) < 12);
                if ($urandom_range(0, 99) < 4) weight_over = ~weight_over;
                model_step();
                exp_q.push_back(model_outs());
            end
        end

        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_door_controller

`default_nettype wire
